// File: rtl/signed_divider_seq.sv
// Sequential signed restoring divider: 5-bit signed dividend / 4-bit signed divisor.
// Latency: 6 cycles from the start edge to the done pulse; a zero divisor takes 1 cycle.
// Backpressure: none; start is ignored while busy and is accepted in IDLE or in the DONE cycle.
//
// Ports:
//   i_clk          clock; all state changes on the rising edge
//   i_reset        synchronous active-high reset; aborts any operation in progress
//   i_start        request; sampled only while o_busy is low
//   i_dividend     signed dividend (DIVIDEND_W bits), captured with i_start
//   i_divisor      signed divisor (DIVISOR_W bits), captured with i_start
//   o_busy         high while an operation is in progress
//   o_done         one-cycle pulse when the results are updated
//   o_quotient     signed quotient (DIVIDEND_W+1 bits), truncated toward zero
//   o_remainder    signed remainder (DIVISOR_W bits), carries the dividend's sign
//   o_div_by_zero  set with o_done when the captured divisor was zero
module signed_divider_seq #(
    parameter int DIVIDEND_W = 5,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic [DIVIDEND_W-1:0] i_dividend,
    input  logic [DIVISOR_W-1:0]  i_divisor,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [DIVIDEND_W:0]   o_quotient,
    output logic [DIVISOR_W-1:0]  o_remainder,
    output logic                  o_div_by_zero
);

    localparam int CNT_W = $clog2(DIVIDEND_W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    // Dividend magnitude, consumed MSB-first by shifting left each iteration.
    logic [DIVIDEND_W-1:0] r_dvd_mag;
    logic [DIVISOR_W-1:0]  r_dsr_mag;
    // Partial remainder is always < |divisor| <= 2^(DIVISOR_W-1), so DIVISOR_W bits suffice.
    logic [DIVISOR_W-1:0]  r_prem;
    logic [DIVIDEND_W-1:0] r_quo_mag;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_q_neg;
    logic                  r_r_neg;
    logic                  r_dz;

    // Operand magnitudes. The most negative value maps to 2^(W-1), which still
    // fits the unsigned W-bit field (-16 -> 16, -8 -> 8).
    logic [DIVIDEND_W-1:0] w_dvd_abs;
    logic [DIVISOR_W-1:0]  w_dsr_abs;
    logic                  w_accept;
    logic                  w_dsr_zero;

    assign w_dvd_abs  = i_dividend[DIVIDEND_W-1] ? (-i_dividend) : i_dividend;
    assign w_dsr_abs  = i_divisor[DIVISOR_W-1]  ? (-i_divisor)  : i_divisor;
    assign w_accept   = i_start && (r_state != S_RUN);
    assign w_dsr_zero = (i_divisor == '0);

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    // One extra bit holds the shifted value (up to 2*|divisor|-1).
    logic [DIVISOR_W:0]    w_shift;
    logic [DIVISOR_W:0]    w_dsr_ext;
    logic [DIVISOR_W:0]    w_diff;
    logic                  w_ge;
    logic [DIVISOR_W-1:0]  w_prem_nxt;

    assign w_shift    = {r_prem, r_dvd_mag[DIVIDEND_W-1]};
    assign w_dsr_ext  = {1'b0, r_dsr_mag};
    assign w_diff     = w_shift - w_dsr_ext;
    assign w_ge       = (w_shift >= w_dsr_ext);
    // Either branch is < |divisor|, so the top bit is always zero and can be dropped.
    assign w_prem_nxt = w_ge ? w_diff[DIVISOR_W-1:0] : w_shift[DIVISOR_W-1:0];

    // Sign correction of the final magnitudes. The quotient is widened by one bit
    // first so that +16 (from -16 / -1) is representable.
    logic [DIVIDEND_W:0]   w_quo_ext;
    logic [DIVIDEND_W:0]   w_quo_signed;
    logic [DIVISOR_W-1:0]  w_rem_signed;
    logic                  w_last;

    assign w_quo_ext    = {1'b0, r_quo_mag};
    assign w_quo_signed = r_q_neg ? (-w_quo_ext) : w_quo_ext;
    assign w_rem_signed = r_r_neg ? (-r_prem) : r_prem;
    assign w_last       = (r_cnt == CNT_W'(DIVIDEND_W));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_dvd_mag     <= '0;
            r_dsr_mag     <= '0;
            r_prem        <= '0;
            r_quo_mag     <= '0;
            r_cnt         <= '0;
            r_q_neg       <= 1'b0;
            r_r_neg       <= 1'b0;
            r_dz          <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_quotient    <= '0;
            o_remainder   <= '0;
            o_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                // DONE behaves exactly like IDLE for accepting a new start; it
                // only differs in that o_done was high during this cycle.
                S_IDLE, S_DONE: begin
                    o_done <= 1'b0;
                    if (w_accept) begin
                        r_dvd_mag     <= w_dvd_abs;
                        r_dsr_mag     <= w_dsr_abs;
                        r_q_neg       <= i_dividend[DIVIDEND_W-1] ^ i_divisor[DIVISOR_W-1];
                        r_r_neg       <= i_dividend[DIVIDEND_W-1];
                        r_dz          <= w_dsr_zero;
                        r_prem        <= '0;
                        r_quo_mag     <= '0;
                        r_cnt         <= '0;
                        o_busy        <= 1'b1;
                        o_div_by_zero <= 1'b0;
                        r_state       <= S_RUN;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end

                S_RUN: begin
                    // A zero divisor finishes on the first RUN edge without iterating.
                    if (r_dz || w_last) begin
                        o_busy  <= 1'b0;
                        o_done  <= 1'b1;
                        r_state <= S_DONE;
                        if (r_dz) begin
                            o_quotient    <= '0;
                            o_remainder   <= '0;
                            o_div_by_zero <= 1'b1;
                        end else begin
                            o_quotient    <= w_quo_signed;
                            o_remainder   <= w_rem_signed;
                            o_div_by_zero <= 1'b0;
                        end
                    end else begin
                        r_prem    <= w_prem_nxt;
                        r_dvd_mag <= {r_dvd_mag[DIVIDEND_W-2:0], 1'b0};
                        r_quo_mag <= {r_quo_mag[DIVIDEND_W-2:0], w_ge};
                        r_cnt     <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    o_busy  <= 1'b0;
                    o_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_signed_divider_seq.sv
// Directed bench for signed_divider_seq: reset, latency, signs/extremes, divide by zero,
// start handshake, mid-operation reset, and a batch of random operand pairs.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
module tb_signed_divider_seq;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] dvd;
    logic [3:0] dsr;
    logic       busy;
    logic       done;
    logic [5:0] quo;
    logic [3:0] rem;
    logic       dz;

    int n_checks;
    int n_errors;

    signed_divider_seq #(
        .DIVIDEND_W (5),
        .DIVISOR_W  (4)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_dividend    (dvd),
        .i_divisor     (dsr),
        .o_busy        (busy),
        .o_done        (done),
        .o_quotient    (quo),
        .o_remainder   (rem),
        .o_div_by_zero (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one operation for exactly one edge; returns just after that edge.
    task automatic start_op(input logic [4:0] a, input logic [3:0] b);
        start = 1'b1;
        dvd   = a;
        dsr   = b;
        tick();
        start = 1'b0;
    endtask

    // Waits (bounded) for the done pulse; lat counts edges after the start edge.
    task automatic wait_done(output int lat, output bit got);
        got = 1'b0;
        lat = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            tick();
            lat++;
            if (done === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dsr   = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++;
        if (quo !== 6'd0) begin n_errors++; $display("FAIL reset_quotient got=%0d exp=0", quo); end
        n_checks++;
        if (rem !== 4'd0) begin n_errors++; $display("FAIL reset_remainder got=%0d exp=0", rem); end
        n_checks++;
        if (dz !== 1'b0) begin n_errors++; $display("FAIL reset_div_by_zero got=%b exp=0", dz); end
    endtask

    task automatic test_latency();
        start_op(5'd15, 4'd7);
        // busy must be high after edges N..N+5 with no done
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_errors++; $display("FAIL lat_busy_edge0 got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_checks++;
            if ({busy, done} !== 2'b10) begin
                n_errors++;
                $display("FAIL lat_busy_edge%0d got busy=%b done=%b exp busy=1 done=0", k, busy, done);
            end
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_errors++; $display("FAIL lat_done_edge6 got busy=%b done=%b exp busy=0 done=1", busy, done);
        end
        n_checks++;
        if ($signed(quo) !== 6'sd2) begin n_errors++; $display("FAIL lat_quotient got=%0d exp=2", $signed(quo)); end
        n_checks++;
        if ($signed(rem) !== 4'sd1) begin n_errors++; $display("FAIL lat_remainder got=%0d exp=1", $signed(rem)); end
        n_checks++;
        if (dz !== 1'b0) begin n_errors++; $display("FAIL lat_div_by_zero got=%b exp=0", dz); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_errors++; $display("FAIL lat_done_pulse got=%b exp=0", done); end
        n_checks++;
        if ($signed(quo) !== 6'sd2) begin n_errors++; $display("FAIL lat_quotient_hold got=%0d exp=2", $signed(quo)); end
    endtask

    task automatic test_signs();
        int va [5] = '{-16, -16, 13, -8, 0};
        int vb [5] = '{ -1,   7, -4, -8, 5};
        int eq [5] = '{ 16,  -2, -3,  1, 0};
        int er [5] = '{  0,  -2,  1,  0, 0};
        int lat;
        bit got;
        for (int i = 0; i < 5; i++) begin
            start_op(5'(va[i]), 4'(vb[i]));
            wait_done(lat, got);
            n_checks++;
            if (!got || lat != 6) begin
                n_errors++;
                $display("FAIL sign%0d_latency got done=%b after %0d edges exp done after 6", i, got, lat);
            end
            n_checks++;
            if (int'($signed(quo)) != eq[i]) begin
                n_errors++;
                $display("FAIL sign%0d_quotient %0d/%0d got=%0d exp=%0d", i, va[i], vb[i], $signed(quo), eq[i]);
            end
            n_checks++;
            if (int'($signed(rem)) != er[i]) begin
                n_errors++;
                $display("FAIL sign%0d_remainder %0d/%0d got=%0d exp=%0d", i, va[i], vb[i], $signed(rem), er[i]);
            end
            tick();
        end
    endtask

    task automatic test_div_zero();
        int lat;
        bit got;
        start_op(5'd9, 4'd0);
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_errors++; $display("FAIL dz_busy got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        tick();
        n_checks++;
        if ({busy, done, dz} !== 3'b011) begin
            n_errors++; $display("FAIL dz_done got busy=%b done=%b dz=%b exp busy=0 done=1 dz=1", busy, done, dz);
        end
        n_checks++;
        if (quo !== 6'd0 || rem !== 4'd0) begin
            n_errors++; $display("FAIL dz_results got q=%0d r=%0d exp q=0 r=0", $signed(quo), $signed(rem));
        end
        tick();
        n_checks++;
        if ({done, dz} !== 2'b01) begin
            n_errors++; $display("FAIL dz_hold got done=%b dz=%b exp done=0 dz=1", done, dz);
        end
        start_op(5'd6, 4'd3);
        n_checks++;
        if (dz !== 1'b0) begin n_errors++; $display("FAIL dz_clear_on_start got=%b exp=0", dz); end
        wait_done(lat, got);
        n_checks++;
        if (!got || int'($signed(quo)) != 2 || int'($signed(rem)) != 0 || dz !== 1'b0) begin
            n_errors++;
            $display("FAIL dz_followup got done=%b q=%0d r=%0d dz=%b exp done=1 q=2 r=0 dz=0",
                     got, $signed(quo), $signed(rem), dz);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        bit got;
        start_op(5'd15, 4'd7);          // edge N
        tick();                         // edge N+1
        start = 1'b1;
        dvd   = 5'd4;
        dsr   = 4'd2;
        for (int k = 2; k <= 4; k++) begin
            tick();                     // edges N+2..N+4, start ignored
            n_checks++;
            if ({busy, done} !== 2'b10) begin
                n_errors++;
                $display("FAIL b2b_ignore_edge%0d got busy=%b done=%b exp busy=1 done=0", k, busy, done);
            end
        end
        start = 1'b0;
        tick();                         // edge N+5
        tick();                         // edge N+6
        n_checks++;
        if (done !== 1'b1 || int'($signed(quo)) != 2 || int'($signed(rem)) != 1) begin
            n_errors++;
            $display("FAIL b2b_first got done=%b q=%0d r=%0d exp done=1 q=2 r=1", done, $signed(quo), $signed(rem));
        end
        // start presented during the DONE cycle
        start = 1'b1;
        dvd   = 5'(-9);
        dsr   = 4'd2;
        tick();
        start = 1'b0;
        n_checks++;
        if ({busy, done} !== 2'b10) begin
            n_errors++; $display("FAIL b2b_accept got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        n_checks++;
        if (int'($signed(quo)) != 2) begin
            n_errors++; $display("FAIL b2b_quotient_hold got=%0d exp=2", $signed(quo));
        end
        wait_done(lat, got);
        n_checks++;
        if (!got || lat != 6) begin
            n_errors++; $display("FAIL b2b_second_latency got done=%b after %0d edges exp 6", got, lat);
        end
        n_checks++;
        if (int'($signed(quo)) != -4 || int'($signed(rem)) != -1) begin
            n_errors++;
            $display("FAIL b2b_second got q=%0d r=%0d exp q=-4 r=-1", $signed(quo), $signed(rem));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        bit got;
        bit seen;
        start_op(5'd14, 4'd3);          // edge N
        tick();                         // N+1
        tick();                         // N+2
        rst = 1'b1;
        tick();                         // N+3, reset sampled
        n_checks++;
        if ({busy, done, dz} !== 3'b000 || quo !== 6'd0 || rem !== 4'd0) begin
            n_errors++;
            $display("FAIL midrst_outputs got busy=%b done=%b dz=%b q=%0d r=%0d exp all 0",
                     busy, done, dz, $signed(quo), $signed(rem));
        end
        rst  = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin n_errors++; $display("FAIL midrst_no_done got activity=1 exp 0"); end
        start_op(5'd14, 4'd3);
        wait_done(lat, got);
        n_checks++;
        if (!got || int'($signed(quo)) != 4 || int'($signed(rem)) != 2) begin
            n_errors++;
            $display("FAIL midrst_restart got done=%b q=%0d r=%0d exp done=1 q=4 r=2",
                     got, $signed(quo), $signed(rem));
        end
        tick();
    endtask

    task automatic test_random();
        int lat;
        bit got;
        int sa, sb, eq, er, gq, gr;
        int n_ok;
        int n_bad;
        logic [4:0] a;
        logic [3:0] b;
        n_ok  = 0;
        n_bad = 0;
        for (int i = 0; i < 50; i++) begin
            a  = 5'($urandom_range(0, 31));
            b  = 4'($urandom_range(1, 15));
            sa = int'($signed(a));
            sb = int'($signed(b));
            eq = sa / sb;               // SV integer division truncates toward zero
            er = sa % sb;
            start_op(a, b);
            wait_done(lat, got);
            gq = int'($signed(quo));
            gr = int'($signed(rem));
            n_checks++;
            if (!got || lat != 6 || gq != eq || gr != er) begin
                n_errors++;
                n_bad++;
                $display("FAIL rand%0d %0d/%0d got done=%b lat=%0d q=%0d r=%0d exp q=%0d r=%0d",
                         i, sa, sb, got, lat, gq, gr, eq, er);
            end else begin
                n_ok++;
            end
            n_checks++;
            if (sa != gq * sb + gr || (gr < 0 ? -gr : gr) >= (sb < 0 ? -sb : sb)) begin
                n_errors++;
                $display("FAIL rand%0d_invariant %0d/%0d got q=%0d r=%0d", i, sa, sb, gq, gr);
            end
            if ($urandom_range(0, 1) == 1) tick();
        end
        $display("random operands: %0d correct, %0d wrong", n_ok, n_bad);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        dvd   = '0;
        dsr   = '0;
        test_reset();
        test_latency();
        test_signs();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
